// File: rtl/result_fmt_pkg.sv
// Shared types and constants for the ALU result formatter.
// Optional leading-zero suppression is enabled with RESULT_FMT_ZSUP_EN.
package result_fmt_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned RES_W  = DIGITS * NIB_W;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = $clog2(DIGITS);

  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    HEX,
    CR,
    LF
  } state_t;

  // Nibble idx of word w, idx 0 is least significant.
  function automatic logic [NIB_W-1:0] nibble_at(input logic [RES_W-1:0] w,
                                                 input logic [CNT_W-1:0] idx);
    return w[NIB_W*idx +: NIB_W];
  endfunction

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex2ascii (
  input  logic [3:0] nib,
  output logic [7:0] ascii_c
);

  always_comb begin
    if (nib < 4'd10) ascii_c = 8'h30 + 8'(nib);
    else             ascii_c = 8'h37 + 8'(nib);
  end

endmodule

// File: rtl/alu_result_fmt.sv
// Captures the ALU result on alu_done and streams it as ASCII hex + CR LF over valid/ready.
// Define RESULT_FMT_ZSUP_EN to skip leading zero nibbles.
module alu_result_fmt
  import result_fmt_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  result,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              busy,
  output logic              drop
);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [RES_W-1:0]    shreg, shreg_nxt;
  logic [BYTE_W-1:0]   data_nxt;
  logic                valid_nxt, busy_nxt, drop_nxt;
  logic [CNT_W-1:0]    first_idx_c;
  logic [NIB_W-1:0]    sel_nib_c;
  logic [BYTE_W-1:0]   sel_ascii_c;
  logic                xfer_c;

  assign xfer_c = tx_valid && tx_ready;

`ifdef RESULT_FMT_ZSUP_EN
  // Index of the most significant nonzero nibble; zero result yields index 0.
  always_comb begin
    first_idx_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nibble_at(result, CNT_W'(i)) != '0) first_idx_c = CNT_W'(i);
    end
  end
`else
  assign first_idx_c = CNT_W'(DIGITS - 1);
`endif

  // In IDLE the first digit comes straight from result; otherwise the next digit down.
  always_comb begin
    if (state == IDLE) sel_nib_c = nibble_at(result, first_idx_c);
    else               sel_nib_c = nibble_at(shreg, CNT_W'(cnt - 1'b1));
  end

  hex2ascii u_hex2ascii (
    .nib     (sel_nib_c),
    .ascii_c (sel_ascii_c)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    data_nxt  = tx_data;
    valid_nxt = tx_valid;
    busy_nxt  = busy;
    drop_nxt  = alu_done && (state != IDLE);
    case (state)
      IDLE: begin
        if (alu_done) begin
          shreg_nxt = result;
          cnt_nxt   = first_idx_c;
          data_nxt  = sel_ascii_c;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = HEX;
        end
      end
      HEX: begin
        if (xfer_c) begin
          if (cnt == '0) begin
            data_nxt  = ASCII_CR;
            state_nxt = CR;
          end else begin
            cnt_nxt  = CNT_W'(cnt - 1'b1);
            data_nxt = sel_ascii_c;
          end
        end
      end
      CR: begin
        if (xfer_c) begin
          data_nxt  = ASCII_LF;
          state_nxt = LF;
        end
      end
      LF: begin
        if (xfer_c) begin
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shreg    <= shreg_nxt;
      tx_data  <= data_nxt;
      tx_valid <= valid_nxt;
      busy     <= busy_nxt;
      drop     <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_fmt.sv
// Directed table-driven bench for alu_result_fmt; expectations follow RESULT_FMT_ZSUP_EN.
module tb_alu_result_fmt;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        alu_done = 1'b0;
  logic [31:0] result = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        drop;

  always #5 clk = ~clk;

  alu_result_fmt dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .alu_done (alu_done),
    .result   (result),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .busy     (busy),
    .drop     (drop)
  );

  typedef struct {
    logic [31:0] res;
    bit          toggle;
    int          second_at;
    logic [31:0] second_val;
    int          exp_drops;
    logic [79:0] bytes_exp;
    int          n;
  } vec_t;

  vec_t       vecs[8];
  int         passed = 0;
  int         total = 0;
  logic [7:0] got[$];
  int         hs_err = 0;
  int         drop_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  // Collect transferred bytes, count drop pulses, and flag data changing under a stall.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (prev_stall && (!tx_valid || tx_data != prev_data)) hs_err <= hs_err + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
      if (drop) drop_cnt <= drop_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   c;
    int   d0;
    int   h0;
    bit   done;
    logic [79:0] e;
    got.delete();
    d0 = drop_cnt;
    h0 = hs_err;
    c = 0;
    done = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    alu_done = 1'b1;
    result   = v.res;
    @(posedge clk);
    #1;
    check($sformatf("v%0d latency valid", idx), 32'(tx_valid), 32'd1);
    check($sformatf("v%0d latency busy", idx), 32'(busy), 32'd1);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      alu_done = 1'b0;
      result   = ~v.res;
      if (!busy) begin
        done = 1'b1;
      end else begin
        c++;
        tx_ready = v.toggle ? ~tx_ready : 1'b1;
        if (c == v.second_at) begin
          alu_done = 1'b1;
          result   = v.second_val;
        end
      end
    end
    check($sformatf("v%0d finished", idx), 32'(done), 32'd1);
    if (!v.toggle) check($sformatf("v%0d busy cycles", idx), 32'(c), 32'(v.n));
    check($sformatf("v%0d byte count", idx), 32'(got.size()), 32'(v.n));
    for (int k = 0; k < v.n && k < got.size(); k++) begin
      e = v.bytes_exp >> ((v.n - 1 - k) * 8);
      check($sformatf("v%0d byte %0d", idx, k), 32'(got[k]), 32'(e[7:0]));
    end
    repeat (3) @(negedge clk);
    check($sformatf("v%0d idle after", idx), 32'({busy, tx_valid}), 32'd0);
    check($sformatf("v%0d no extra bytes", idx), 32'(got.size()), 32'(v.n));
    check($sformatf("v%0d drops", idx), 32'(drop_cnt - d0), 32'(v.exp_drops));
    check($sformatf("v%0d stall stability", idx), 32'(hs_err - h0), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000008C, 1'b0, 0, 32'h0, 0, 80'({"0000008C", 8'h0D, 8'h0A}), 10};
    vecs[1] = '{32'hFFFFFFFF, 1'b1, 0, 32'h0, 0, 80'({"FFFFFFFF", 8'h0D, 8'h0A}), 10};
    vecs[2] = '{32'h12345678, 1'b0, 3, 32'hDEADBEEF, 1, 80'({"12345678", 8'h0D, 8'h0A}), 10};
    vecs[3] = '{32'h9ABCDEF0, 1'b0, 10, 32'h11111111, 1, 80'({"9ABCDEF0", 8'h0D, 8'h0A}), 10};
    vecs[4] = '{32'h00000000, 1'b0, 0, 32'h0, 0, 80'({"00000000", 8'h0D, 8'h0A}), 10};
    vecs[5] = '{32'hA0B1C2D3, 1'b1, 0, 32'h0, 0, 80'({"A0B1C2D3", 8'h0D, 8'h0A}), 10};
    vecs[6] = '{32'h00F00E00, 1'b0, 0, 32'h0, 0, 80'({"00F00E00", 8'h0D, 8'h0A}), 10};
    vecs[7] = '{32'hCAFEF00D, 1'b0, 0, 32'h0, 0, 80'({"CAFEF00D", 8'h0D, 8'h0A}), 10};
`ifdef RESULT_FMT_ZSUP_EN
    vecs[0].bytes_exp = 80'({"8C", 8'h0D, 8'h0A});
    vecs[0].n = 4;
    vecs[4].bytes_exp = 80'({"0", 8'h0D, 8'h0A});
    vecs[4].n = 3;
    vecs[6].bytes_exp = 80'({"F00E00", 8'h0D, 8'h0A});
    vecs[6].n = 8;
`endif

    #1;
    check("reset tx_valid", 32'(tx_valid), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'h00);
    check("reset busy", 32'(busy), 32'd0);
    check("reset drop", 32'(drop), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset after the 4th byte of a message aborts it.
    begin
      bit reached;
      reached = 1'b0;
      got.delete();
      @(negedge clk);
      tx_ready = 1'b1;
      alu_done = 1'b1;
      result   = 32'hCAFEF00D;
      for (int k = 0; k < 50 && !reached; k++) begin
        @(negedge clk);
        alu_done = 1'b0;
        if (got.size() >= 4) reached = 1'b1;
      end
      check("rst 4 bytes reached", 32'(reached), 32'd1);
      if (got.size() >= 4) check("rst 4th byte", 32'(got[3]), 32'h45);
      n_rst = 1'b0;
      #1;
      check("rst async tx_valid", 32'(tx_valid), 32'd0);
      check("rst async tx_data", 32'(tx_data), 32'h00);
      check("rst async busy", 32'(busy), 32'd0);
      check("rst async drop", 32'(drop), 32'd0);
      repeat (2) @(negedge clk);
      check("rst no bytes held", 32'(got.size()), 32'd4);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst no resume", 32'({busy, tx_valid}), 32'd0);
      check("rst no trailing bytes", 32'(got.size()), 32'd4);
    end
    run_vec(vecs[7], 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_result_fmt.md
# alu_result_fmt

Downstream stage of the calculator ALU: captures the 32-bit `result` on each `alu_done` pulse and streams it to the UART transmitter as ASCII hex text terminated by CR LF. Sits between `alu` and the UART TX byte interface. Bytes leave over a valid/ready handshake, so TX backpressure is absorbed here and the ALU never stalls.

## Interface
- No parameters; widths are fixed by the ALU (32-bit result) and the UART (8-bit byte).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `alu_done`  in  1  one-cycle pulse from `alu`; `result` is valid in the same cycle.
- `result`  in  32  ALU result, unsigned bit pattern; the ALU has already applied signedness.
- `tx_ready`  in  1  UART TX can accept a byte this cycle.
- `tx_valid`  out  1  `tx_data` holds a byte to send.
- `tx_data`  out  8  ASCII byte.
- `busy`  out  1  a message is in progress; high from capture until LF is accepted.
- `drop`  out  1  one-cycle pulse: an `alu_done` arrived while busy and was discarded.

## Operation
- FSM states: IDLE, HEX, CR, LF.
- IDLE
  - On `alu_done`: latch `result` into the shift register, set the digit counter to 7, go to HEX.
  - Load `tx_data` with the first digit, assert `tx_valid` and `busy`.
- HEX
  - Emits the nibble indexed by the counter, most significant first.
  - Digit encoding: 0–9 map to 0x30+n; A–F map to 0x41+(n−10), uppercase only.
  - On each transfer (`tx_valid && tx_ready`): decrement the counter and load the next digit.
  - A transfer at counter 0 moves to CR.
- CR: `tx_data` = 0x0D. A transfer moves to LF.
- LF: `tx_data` = 0x0A. A transfer moves to IDLE, deasserts `tx_valid` and `busy`.
- Handshake rules
  - `tx_data` and `tx_valid` are registered.
  - Once `tx_valid` rises, `tx_data` holds stable until the transfer.
  - `tx_valid` never drops without a transfer.
- `alu_done` in any state other than IDLE
  - Ignored; captured data is unchanged.
  - `drop` pulses high on the next cycle.
  - This includes the cycle in which LF is accepted.
- `result` is sampled only in the `alu_done` cycle; later changes have no effect.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `busy`=0, `drop`=0, state IDLE, counter 0, shift register 0.
- Reset asserted mid-message aborts immediately. No partial byte is retained and no CR/LF is emitted afterwards.
- Latency: `alu_done` sampled at edge N gives `tx_valid`=1 and `busy`=1 after edge N, i.e. one cycle.
- Throughput with `tx_ready` tied high: one byte per cycle.
  - A full message is 10 bytes in 10 cycles; `busy` falls after the LF edge.
- Minimum `alu_done` spacing without a drop: 11 cycles at full `tx_ready`.

## Configuration
- Macro: `RESULT_FMT_ZSUP_EN`.
- Defined: leading-zero nibbles are skipped.
  - On capture, the counter starts at the index of the most significant nonzero nibble.
  - Result 0 emits the single digit "0".
  - Message length ranges from 3 bytes ("0\r\n") to 10 bytes.
- Undefined: all 8 digits are always emitted, with fixed 10-byte messages. No priority encoder is built.

## Structure
- Package `result_fmt_pkg`:
  - state enum (IDLE, HEX, CR, LF);
  - constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A;
  - `DIGITS`=8.
- Sub-module `hex2ascii`: combinational, 4-bit nibble in, 8-bit ASCII out. Instantiated once on the selected nibble.
- The leading-zero priority encoder is inline under `RESULT_FMT_ZSUP_EN`.

## Test plan
- `result`=0x0000008C (14×10), `tx_ready`=1:
  - macro undefined: bytes 30 30 30 30 30 30 38 43 0D 0A on consecutive cycles.
  - macro defined: 38 43 0D 0A.
- `result`=0xFFFFFFFF, `tx_ready` toggling 1/0 every cycle:
  - bytes are eight 0x46, then 0D 0A;
  - `tx_data` is stable whenever `tx_valid`=1 and `tx_ready`=0;
  - no byte is duplicated or lost.
- `result`=0x00000000 with the macro defined: bytes 30 0D 0A; `busy` is high for 3 cycles.
- Second `alu_done` 3 cycles after the first (`result`=0x12345678, then 0xDEADBEEF):
  - `drop` pulses once;
  - output is "12345678\r\n" only.
- `n_rst` pulled low after the 4th byte of a message:
  - all outputs return to reset values asynchronously;
  - a new `alu_done` after release yields a complete, correct message.
- `alu_done` in the same cycle LF is accepted: `drop` pulses and no new message starts.
